rob_nway: RTL and testbench
===========================

# rob_nway

Parametrised reorder buffer for the out-of-order core, sitting between decode/rename and the architectural register file and monitor. It allocates one entry per cycle in program order and accepts results from `N_CDB` common data buses in parallel. It retires one completed instruction per cycle in order, with full/empty/count flow control. It raises a precise flush when a mispredicted branch or jump reaches the head.

## Interface
Parameters
- `DEPTH`, 16: number of entries; must be a power of two and at least 4.
- `N_CDB`, 2: number of CDB write-back ports.
- `PTR_W`, `$clog2(DEPTH)`: tag/index width. Tag = entry index.

Ports
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alloc_valid`  in  1  decode requests an entry.
- `alloc_ready`  out  1  entry available: `!full && !flush`.
- `alloc_inst`  in  32  instruction word.
- `alloc_pc`  in  32  instruction PC.
- `alloc_tag`  out  PTR_W  tag assigned on handshake; equals the tail index.
- `cdb_valid`  in  N_CDB  per-port result valid.
- `cdb_tag`  in  N_CDB*PTR_W  per-port destination tag.
- `cdb_wdata`  in  N_CDB*32  per-port result (rd value).
- `cdb_mispred`  in  N_CDB  per-port control-flow mispredict.
- `cdb_target`  in  N_CDB*32  per-port correct next PC.
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_tag`  out  PTR_W  head index.
- `commit_rd`  out  5  `inst[11:7]`.
- `commit_wdata`  out  32  result.
- `commit_pc`  out  32  PC.
- `commit_inst`  out  32  instruction word.
- `commit_pc_next`  out  32  target if mispredicted, else PC+4.
- `flush`  out  1  head is a mispredicted instruction retiring now.
- `flush_pc`  out  32  restart PC (equals `commit_pc_next`).
- `count`  out  PTR_W+1  occupied entries.
- `empty`  out  1  no occupied entries.
- `full`  out  1  all entries occupied.
- `order`  out  64  retire sequence number of the head.

## Operation
- Pointers `head` and `tail` are PTR_W+1 bits wide. The extra MSB distinguishes full from empty.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Allocate on `alloc_valid && alloc_ready`:
  - write inst and pc into `entry[tail]`;
  - set valid=1, done=0, mispred=0;
  - increment tail.
- Per CDB port p with `cdb_valid[p]`: if `entry[cdb_tag[p]].valid`, set done=1 and latch wdata, mispred and target.
  - A CDB write to an invalid entry is ignored.
  - If two ports carry the same tag, the lowest port index wins; the bench flags this as illegal.
- Retire: `commit_valid = entry[head].valid && entry[head].done`. It is combinational from registered state. There is no back-pressure; the consumer always accepts.
  - On retire, clear `entry[head].valid`, increment head, increment order.
- Flush: `flush = commit_valid && entry[head].mispred`. On the next edge:
  - clear every valid bit;
  - set `head = tail = 0`;
  - keep `order` incremented by 1.
  - Allocation and CDB writes in the flush cycle are discarded.
- Simultaneous allocate and retire is allowed; count is unchanged.
- When full, allocation is refused even if retiring that cycle.
- Wrap-around: low index bits wrap modulo DEPTH; the MSB toggles.

## Timing
- Reset values:
  - head=tail=0, count=0, empty=1, full=0, alloc_ready=1;
  - commit_valid=0, flush=0, order=0;
  - all valid/done/mispred bits =0.
  - Data fields are not reset.
- alloc_tag is valid in the handshake cycle.
- A CDB write in cycle t makes the entry retirable in cycle t+1. There is no same-cycle bypass to commit.
- Minimum latency alloc→retire is 2 cycles (alloc t, CDB t+1, commit t+2).
- Throughput: 1 alloc and 1 retire per cycle, N_CDB completions per cycle.
- `rst` asserted mid-operation discards all contents at the next edge and overrides flush.

## Structure
- Shared package `rv32i_types` gains:
  - `ROB_DEPTH` and `ROB_TAG_W` constants;
  - `rob_entry_t` (inst, pc, wdata, target, valid, done, mispred), built with the package tag width.
- Sub-module `rob_cdb_select`: per-entry N_CDB tag match with fixed priority. Outputs hit, wdata, mispred and target. Instantiated once per entry.
- Top level holds pointers, count, flags, order counter and commit/flush muxing.

## Test plan
- Reset, then allocate 3 entries (pc 0x100, 0x104, 0x108), CDB port 0 writes tags 0, 1, 2 with 0x11, 0x22, 0x33 → commits on consecutive cycles with wdata 0x11/0x22/0x33, order 0/1/2, empty=1 afterwards.
- Out-of-order completion: tag 2 done, then tag 0 in the same cycle on port 1 as tag 1 on port 0 → commit order strictly 0, 1, 2; no commit before tag 0 is done.
- Fill DEPTH=16 entries → full=1, alloc_ready=0, count=16. Retire one and allocate → tag reuses index 0 with the MSB toggled; count returns to 16.
- Mispredict: tags 0–4 allocated, tag 1 completes with mispred and target 0x200, tags 0 and 1 done → flush=1 with flush_pc=0x200 in the tag-1 commit cycle. Next cycle count=0 and a late CDB write to tag 3 is ignored.
- Reset asserted mid-stream with 5 entries valid → next cycle count=0, commit_valid=0, order=0.
- CDB write to a never-allocated tag → no state change and no commit.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types; the reorder buffer entry layout and default sizing live here.
package rv32i_types;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [31:0] target;
        logic        valid;
        logic        done;
        logic        mispred;
    } rob_entry_t;

    function automatic logic [31:0] rob_next_pc(input logic [31:0] pc, input logic mispred,
                                                input logic [31:0] target);
        return mispred ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/rob_cdb_select.sv
// Per-entry CDB tag match; the lowest-numbered matching port supplies the result.
module rob_cdb_select #(
    parameter int N_CDB = 2,
    parameter int PTR_W = 4,
    parameter int IDX   = 0
) (
    input  logic [N_CDB-1:0]       cdb_valid_i,
    input  logic [N_CDB*PTR_W-1:0] cdb_tag_i,
    input  logic [N_CDB*32-1:0]    cdb_wdata_i,
    input  logic [N_CDB-1:0]       cdb_mispred_i,
    input  logic [N_CDB*32-1:0]    cdb_target_i,
    output logic                   hit_o,
    output logic [31:0]            wdata_o,
    output logic                   mispred_o,
    output logic [31:0]            target_o
);
    always_comb begin
        hit_o     = 1'b0;
        wdata_o   = '0;
        mispred_o = 1'b0;
        target_o  = '0;
        // Walk from the highest port down so the lowest index overwrites last.
        for (int p = N_CDB - 1; p >= 0; p--) begin
            if (cdb_valid_i[p] && cdb_tag_i[p*PTR_W +: PTR_W] == PTR_W'(IDX)) begin
                hit_o     = 1'b1;
                wdata_o   = cdb_wdata_i[p*32 +: 32];
                mispred_o = cdb_mispred_i[p];
                target_o  = cdb_target_i[p*32 +: 32];
            end
        end
    end
endmodule

// File: rtl/rob_nway.sv
// In-order allocate/retire reorder buffer with N_CDB parallel write-back ports
// and precise flush when a mispredicted instruction reaches the head.
module rob_nway
    import rv32i_types::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int N_CDB = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [31:0]            alloc_inst,
    input  logic [31:0]            alloc_pc,
    output logic [PTR_W-1:0]       alloc_tag,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*PTR_W-1:0] cdb_tag,
    input  logic [N_CDB*32-1:0]    cdb_wdata,
    input  logic [N_CDB-1:0]       cdb_mispred,
    input  logic [N_CDB*32-1:0]    cdb_target,
    output logic                   commit_valid,
    output logic [PTR_W-1:0]       commit_tag,
    output logic [4:0]             commit_rd,
    output logic [31:0]            commit_wdata,
    output logic [31:0]            commit_pc,
    output logic [31:0]            commit_inst,
    output logic [31:0]            commit_pc_next,
    output logic                   flush,
    output logic [31:0]            flush_pc,
    output logic [PTR_W:0]         count,
    output logic                   empty,
    output logic                   full,
    output logic [63:0]            order
);
    logic [PTR_W:0]  head_q, head_d, tail_q, tail_d;
    logic [63:0]     order_q, order_d;
    rob_entry_t      ent_q [DEPTH];
    rob_entry_t      ent_d [DEPTH];
    rob_entry_t      hd;

    logic [DEPTH-1:0]       sel_hit, sel_mis;
    logic [DEPTH-1:0][31:0] sel_wdata, sel_target;

    for (genvar g = 0; g < DEPTH; g++) begin : g_sel
        rob_cdb_select #(.N_CDB(N_CDB), .PTR_W(PTR_W), .IDX(g)) u_sel (
            .cdb_valid_i  (cdb_valid),
            .cdb_tag_i    (cdb_tag),
            .cdb_wdata_i  (cdb_wdata),
            .cdb_mispred_i(cdb_mispred),
            .cdb_target_i (cdb_target),
            .hit_o        (sel_hit[g]),
            .wdata_o      (sel_wdata[g]),
            .mispred_o    (sel_mis[g]),
            .target_o     (sel_target[g])
        );
    end

    logic alloc_fire;

    // The extra pointer MSB separates a full ring from an empty one.
    assign empty       = head_q == tail_q;
    assign full        = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
    assign count       = tail_q - head_q;
    assign alloc_ready = !full && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q[PTR_W-1:0];

    assign hd             = ent_q[head_q[PTR_W-1:0]];
    assign commit_valid   = hd.valid && hd.done;
    assign flush          = commit_valid && hd.mispred;
    assign commit_tag     = head_q[PTR_W-1:0];
    assign commit_rd      = hd.inst[11:7];
    assign commit_wdata   = hd.wdata;
    assign commit_pc      = hd.pc;
    assign commit_inst    = hd.inst;
    assign commit_pc_next = rob_next_pc(hd.pc, hd.mispred, hd.target);
    assign flush_pc       = commit_pc_next;
    assign order          = order_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        order_d = order_q;
        ent_d   = ent_q;
        if (flush) begin
            // Everything younger than the mispredict dies, including this cycle's inputs.
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            order_d = order_q + 64'd1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_hit[i] && ent_q[i].valid) begin
                    ent_d[i].done    = 1'b1;
                    ent_d[i].wdata   = sel_wdata[i];
                    ent_d[i].mispred = sel_mis[i];
                    ent_d[i].target  = sel_target[i];
                end
            end
            if (commit_valid) begin
                ent_d[head_q[PTR_W-1:0]].valid = 1'b0;
                head_d  = head_q + 1'b1;
                order_d = order_q + 64'd1;
            end
            if (alloc_fire) begin
                ent_d[tail_q[PTR_W-1:0]].inst    = alloc_inst;
                ent_d[tail_q[PTR_W-1:0]].pc      = alloc_pc;
                ent_d[tail_q[PTR_W-1:0]].valid   = 1'b1;
                ent_d[tail_q[PTR_W-1:0]].done    = 1'b0;
                ent_d[tail_q[PTR_W-1:0]].mispred = 1'b0;
                tail_d = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            order_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid   <= 1'b0;
                ent_q[i].done    <= 1'b0;
                ent_q[i].mispred <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            order_q <= order_d;
            ent_q   <= ent_d;
        end
    end
endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: hand-derived vector table, directed corner sequences and
// random traffic checked against a program-order queue model.
module tb_rob_nway;
    localparam int DEPTH = 16;
    localparam int N_CDB = 2;
    localparam int PTR_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alloc_valid, alloc_ready;
    logic [31:0]            alloc_inst, alloc_pc;
    logic [PTR_W-1:0]       alloc_tag;
    logic [N_CDB-1:0]       cdb_valid, cdb_mispred;
    logic [N_CDB*PTR_W-1:0] cdb_tag;
    logic [N_CDB*32-1:0]    cdb_wdata, cdb_target;
    logic                   commit_valid, flush, empty, full;
    logic [PTR_W-1:0]       commit_tag;
    logic [4:0]             commit_rd;
    logic [31:0]            commit_wdata, commit_pc, commit_inst, commit_pc_next, flush_pc;
    logic [PTR_W:0]         count;
    logic [63:0]            order;

    rob_nway #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_inst(alloc_inst),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_wdata(commit_wdata), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_pc_next(commit_pc_next), .flush(flush), .flush_pc(flush_pc),
        .count(count), .empty(empty), .full(full), .order(order)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          tag;
        logic [31:0] inst, pc, wdata, target;
        bit          done, mis;
    } ment_t;

    ment_t       q[$];
    int          tail_c;
    logic [63:0] ord;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_inst = '0; alloc_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_wdata = '0; cdb_mispred = '0; cdb_target = '0;
    endtask

    task automatic alloc1(input logic [31:0] pc);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_inst = $urandom;
    endtask

    task automatic cdbw(input int p, input int tag, input logic [31:0] d, input bit mis,
                        input logic [31:0] tgt);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*PTR_W +: PTR_W] = PTR_W'(tag);
        cdb_wdata[p*32 +: 32] = d;
        cdb_mispred[p] = mis;
        cdb_target[p*32 +: 32] = tgt;
    endtask

    // Check all outputs against the model, clock once, then advance the model.
    task automatic cycle();
        bit cv, fl, rdy;
        logic [31:0] iw, pcn;
        ment_t e;
        #1;
        cv  = q.size() > 0 && q[0].done;
        fl  = cv && q[0].mis;
        rdy = q.size() < DEPTH && !fl;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("alloc_ready", 64'(alloc_ready), 64'(rdy));
        chk("alloc_tag", 64'(alloc_tag), 64'(tail_c % DEPTH));
        chk("commit_valid", 64'(commit_valid), 64'(cv));
        chk("flush", 64'(flush), 64'(fl));
        chk("order", order, ord);
        if (cv) begin
            e   = q[0];
            iw  = e.inst;
            pcn = e.mis ? e.target : e.pc + 32'd4;
            chk("commit_tag", 64'(commit_tag), 64'(e.tag));
            chk("commit_wdata", 64'(commit_wdata), 64'(e.wdata));
            chk("commit_pc", 64'(commit_pc), 64'(e.pc));
            chk("commit_inst", 64'(commit_inst), 64'(e.inst));
            chk("commit_rd", 64'(commit_rd), 64'(iw[11:7]));
            chk("commit_pc_next", 64'(commit_pc_next), 64'(pcn));
            chk("flush_pc", 64'(flush_pc), 64'(pcn));
        end
        @(posedge clk);
        if (rst) begin
            q.delete(); tail_c = 0; ord = '0;
        end else if (fl) begin
            q.delete(); tail_c = 0; ord = ord + 64'd1;
        end else begin
            for (int k = 0; k < q.size(); k++) begin
                for (int p = 0; p < N_CDB; p++) begin
                    if (cdb_valid[p] && int'(cdb_tag[p*PTR_W +: PTR_W]) == q[k].tag) begin
                        e = q[k];
                        e.done = 1'b1; e.wdata = cdb_wdata[p*32 +: 32];
                        e.mis = cdb_mispred[p]; e.target = cdb_target[p*32 +: 32];
                        q[k] = e;
                        break;
                    end
                end
            end
            if (cv) begin
                void'(q.pop_front());
                ord = ord + 64'd1;
            end
            if (alloc_valid && rdy) begin
                e = '{tag: tail_c % DEPTH, inst: alloc_inst, pc: alloc_pc, wdata: '0,
                      target: '0, done: 1'b0, mis: 1'b0};
                q.push_back(e);
                tail_c = (tail_c + 1) % (2 * DEPTH);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    typedef struct {
        bit          av;
        logic [31:0] pc;
        bit          cv0;
        int          tag0;
        logic [31:0] w0;
        bit          e_cv;
        logic [31:0] e_wdata;
        logic [63:0] e_order;
        int          e_count;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1, 32'h100, 0, 0, 32'h00, 0, 32'h00, 64'd0, 0};
        tbl[1] = '{1, 32'h104, 1, 0, 32'h11, 0, 32'h00, 64'd0, 1};
        tbl[2] = '{1, 32'h108, 1, 1, 32'h22, 1, 32'h11, 64'd0, 2};
        tbl[3] = '{0, 32'h000, 1, 2, 32'h33, 1, 32'h22, 64'd1, 2};
        tbl[4] = '{0, 32'h000, 0, 0, 32'h00, 1, 32'h33, 64'd2, 1};
        tbl[5] = '{0, 32'h000, 0, 0, 32'h00, 0, 32'h00, 64'd3, 0};

        q.delete(); tail_c = 0; ord = '0;
        idle(); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_cv", 64'(commit_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_order", order, 64'd0);

        // In-order basic flow
        for (int i = 0; i < 6; i++) begin
            idle();
            if (tbl[i].av) alloc1(tbl[i].pc);
            if (tbl[i].cv0) cdbw(0, tbl[i].tag0, tbl[i].w0, 1'b0, 32'h0);
            #1;
            chk($sformatf("tbl%0d_cv", i), 64'(commit_valid), 64'(tbl[i].e_cv));
            if (tbl[i].e_cv) chk($sformatf("tbl%0d_wdata", i), 64'(commit_wdata), 64'(tbl[i].e_wdata));
            chk($sformatf("tbl%0d_order", i), order, tbl[i].e_order);
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
            cycle();
        end
        idle(); #1;
        chk("tbl_empty_after", 64'(empty), 64'd1);

        // Out-of-order completion, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); alloc1(32'h200 + 32'(4*i)); cycle(); end
        idle(); cdbw(0, 2, 32'hC2, 1'b0, 32'h0); cycle();
        idle(); #1; chk("ooo_no_early", 64'(commit_valid), 64'd0);
        cdbw(1, 0, 32'hC0, 1'b0, 32'h0); cdbw(0, 1, 32'hC1, 1'b0, 32'h0); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); #1;
            chk($sformatf("ooo_tag%0d", i), 64'(commit_tag), 64'(i));
            cycle();
        end

        // Fill to full, refuse while retiring, then reuse index 0
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin idle(); alloc1(32'h1000 + 32'(4*i)); cycle(); end
        idle(); #1;
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        cdbw(0, 0, 32'hF0, 1'b0, 32'h0); cycle();
        idle(); alloc1(32'h2000); #1;
        chk("full_refuse_on_retire", 64'(alloc_ready), 64'd0);
        cycle();
        idle(); alloc1(32'h2004); #1;
        chk("wrap_tag", 64'(alloc_tag), 64'd0);
        chk("wrap_count_pre", 64'(count), 64'd15);
        cycle();
        idle(); #1;
        chk("wrap_count_post", 64'(count), 64'd16);
        cycle();

        // Mispredict flush
        do_reset();
        for (int i = 0; i < 5; i++) begin idle(); alloc1(32'h300 + 32'(4*i)); cycle(); end
        idle(); cdbw(0, 0, 32'hA0, 1'b0, 32'h0); cdbw(1, 1, 32'hA1, 1'b1, 32'h200); cycle();
        idle(); cycle();
        idle(); cdbw(0, 2, 32'hA2, 1'b0, 32'h0); alloc1(32'h400); #1;
        chk("mp_flush", 64'(flush), 64'd1);
        chk("mp_flush_pc", 64'(flush_pc), 64'h200);
        chk("mp_ready", 64'(alloc_ready), 64'd0);
        cycle();
        idle(); cdbw(0, 3, 32'hA3, 1'b0, 32'h0); #1;
        chk("mp_count_after", 64'(count), 64'd0);
        cycle();
        idle(); #1;
        chk("mp_late_cdb_cv", 64'(commit_valid), 64'd0);
        chk("mp_late_cdb_count", 64'(count), 64'd0);
        cycle();

        // Reset mid-stream with live entries
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); alloc1(32'h500 + 32'(4*i));
            if (i == 1) cdbw(0, 0, 32'hB0, 1'b0, 32'h0);
            cycle();
        end
        idle(); cdbw(0, 3, 32'hB3, 1'b0, 32'h0); #1;
        chk("mid_pre_count", 64'(count), 64'd5);
        rst = 1'b1; cycle(); rst = 1'b0;
        idle(); #1;
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_cv", 64'(commit_valid), 64'd0);
        chk("mid_order", order, 64'd0);
        cycle();

        // CDB writes to never-allocated tags
        idle(); cdbw(0, 5, 32'hDEAD, 1'b1, 32'h0); cycle();
        idle(); alloc1(32'h600); cycle();
        idle(); alloc1(32'h604); cycle();
        idle(); cdbw(1, 9, 32'hBEEF, 1'b0, 32'h0); cycle();
        idle(); #1;
        chk("stray_cv", 64'(commit_valid), 64'd0);
        chk("stray_count", 64'(count), 64'd2);
        cycle();

        // Random traffic against the queue model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int t0, t1;
            idle();
            if ($urandom_range(3) != 0) alloc1({$urandom_range(32'hFFFF), 2'b00});
            t0 = -1;
            if ($urandom_range(1) == 1) begin
                t0 = (q.size() > 0 && $urandom_range(7) != 0) ? q[$urandom_range(q.size() - 1)].tag
                                                              : int'($urandom_range(DEPTH - 1));
                cdbw(0, t0, $urandom, $urandom_range(11) == 0, $urandom);
            end
            if ($urandom_range(1) == 1) begin
                t1 = (q.size() > 0 && $urandom_range(7) != 0) ? q[$urandom_range(q.size() - 1)].tag
                                                              : int'($urandom_range(DEPTH - 1));
                if (t1 != t0) cdbw(1, t1, $urandom, $urandom_range(11) == 0, $urandom);
            end
            rst = ($urandom_range(199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
